mem_wb_stage: RTL and testbench

//  MEM->WB pipeline register fed by the EX/MEM latch and the data memory.

---
 rtl/mem_wb_stage.sv | 155 +++++++++++++++
 tb/tb_mem_wb_stage.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
// MEM->WB pipeline register with byte/half load alignment, plus a minimum-SAD
// tracker that records the best total and its row over one search window.
module mem_wb_stage #(
    parameter int DATA_W   = 32,
    parameter int REG_W    = 5,
    parameter int NUM_ROWS = 16,
    parameter int CNT_W    = 5
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              Stall,
    input  logic              Flush,
    input  logic              RegWrite,
    input  logic              MemToReg,
    input  logic              movIn,
    input  logic              jumpIn,
    input  logic              ReadSp,
    input  logic [1:0]        whb,
    input  logic [DATA_W-1:0] ALUResult,
    input  logic [DATA_W-1:0] MemReadData,
    input  logic [REG_W-1:0]  WriteReg,
    input  logic [DATA_W-1:0] PCAddress,
    input  logic [DATA_W-1:0] SadTotal,
    input  logic [DATA_W-1:0] row,
    input  logic              SadClear,
    output logic              RegWriteOut,
    output logic              MemToRegOut,
    output logic              movOut,
    output logic              jumpOut,
    output logic              ReadSpOut,
    output logic [DATA_W-1:0] ALUResultOut,
    output logic [DATA_W-1:0] MemDataOut,
    output logic [REG_W-1:0]  WriteRegOut,
    output logic [DATA_W-1:0] PCAddressOut,
    output logic [DATA_W-1:0] BestSad,
    output logic [DATA_W-1:0] BestRow,
    output logic [CNT_W-1:0]  SadCount,
    output logic              SadDone,
    output logic [1:0]        SadState
);

    typedef enum logic [1:0] {IDLE = 2'd0, TRACK = 2'd1, DONE = 2'd2} sad_state_t;

    sad_state_t        state, next_state;
    logic              sample;
    logic              last_row;
    logic [1:0]        off;
    logic [DATA_W-1:0] byte_shift, half_shift, aligned;

    // No valid/ready handshake here: Flush (bubble) beats Stall (hold) beats a
    // normal load; a SAD result is consumed only on a cycle that actually advances.
    assign sample   = ReadSp & RegWrite & ~Stall & ~Flush;
    assign last_row = (SadCount == CNT_W'(NUM_ROWS - 1));

    assign off        = ALUResult[1:0];
    assign byte_shift = MemReadData >> {off, 3'b000};
    assign half_shift = MemReadData >> {off[1], 4'b0000};

    always_comb begin
        aligned = MemReadData;
        case (whb)
            2'b01:   aligned = {{(DATA_W-8){byte_shift[7]}}, byte_shift[7:0]};
            2'b10:   aligned = {{(DATA_W-16){half_shift[15]}}, half_shift[15:0]};
            default: aligned = MemReadData;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            RegWriteOut  <= 1'b0;
            MemToRegOut  <= 1'b0;
            movOut       <= 1'b0;
            jumpOut      <= 1'b0;
            ReadSpOut    <= 1'b0;
            ALUResultOut <= '0;
            MemDataOut   <= '0;
            WriteRegOut  <= '0;
            PCAddressOut <= '0;
        end else if (Flush) begin
            RegWriteOut  <= 1'b0;
            MemToRegOut  <= 1'b0;
            movOut       <= 1'b0;
            jumpOut      <= 1'b0;
            ReadSpOut    <= 1'b0;
            ALUResultOut <= '0;
            MemDataOut   <= '0;
            WriteRegOut  <= '0;
            PCAddressOut <= '0;
        end else if (!Stall) begin
            RegWriteOut  <= RegWrite;
            MemToRegOut  <= MemToReg;
            movOut       <= movIn;
            jumpOut      <= jumpIn;
            ReadSpOut    <= ReadSp;
            ALUResultOut <= ALUResult;
            MemDataOut   <= aligned;
            WriteRegOut  <= WriteReg;
            PCAddressOut <= PCAddress;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // SadClear is deliberately not gated by Stall so a new window can always start.
    always_comb begin
        next_state = state;
        if (SadClear) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:    if (sample) next_state = (NUM_ROWS == 1) ? DONE : TRACK;
                TRACK:   if (sample && last_row) next_state = DONE;
                default: next_state = state;
            endcase
        end
    end

    always_comb begin
        SadDone  = (state == DONE);
        SadState = state;
    end

    // Strict less-than keeps the earliest row on ties.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            BestSad  <= '1;
            BestRow  <= '0;
            SadCount <= '0;
        end else if (SadClear) begin
            BestSad  <= '1;
            BestRow  <= '0;
            SadCount <= '0;
        end else if (sample) begin
            case (state)
                IDLE: begin
                    BestSad  <= SadTotal;
                    BestRow  <= row;
                    SadCount <= CNT_W'(1);
                end
                TRACK: begin
                    if (SadTotal < BestSad) begin
                        BestSad <= SadTotal;
                        BestRow <= row;
                    end
                    SadCount <= SadCount + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: alignment vector table, hand-written stall/flush,
// SAD window and mid-cycle reset sequences, then randomized traffic vs a model.
module tb_mem_wb_stage;

    localparam int DATA_W   = 32;
    localparam int REG_W    = 5;
    localparam int NUM_ROWS = 4;
    localparam int CNT_W    = 5;

    logic              Clk, Rst_n, Stall, Flush, RegWrite, MemToReg, movIn, jumpIn, ReadSp, SadClear;
    logic [1:0]        whb;
    logic [DATA_W-1:0] ALUResult, MemReadData, PCAddress, SadTotal, row;
    logic [REG_W-1:0]  WriteReg;
    logic              RegWriteOut, MemToRegOut, movOut, jumpOut, ReadSpOut, SadDone;
    logic [DATA_W-1:0] ALUResultOut, MemDataOut, PCAddressOut, BestSad, BestRow;
    logic [REG_W-1:0]  WriteRegOut;
    logic [CNT_W-1:0]  SadCount;
    logic [1:0]        SadState;

    int n_cmp = 0;
    int n_err = 0;

    mem_wb_stage #(.DATA_W(DATA_W), .REG_W(REG_W), .NUM_ROWS(NUM_ROWS), .CNT_W(CNT_W)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .Stall(Stall), .Flush(Flush), .RegWrite(RegWrite),
        .MemToReg(MemToReg), .movIn(movIn), .jumpIn(jumpIn), .ReadSp(ReadSp), .whb(whb),
        .ALUResult(ALUResult), .MemReadData(MemReadData), .WriteReg(WriteReg),
        .PCAddress(PCAddress), .SadTotal(SadTotal), .row(row), .SadClear(SadClear),
        .RegWriteOut(RegWriteOut), .MemToRegOut(MemToRegOut), .movOut(movOut),
        .jumpOut(jumpOut), .ReadSpOut(ReadSpOut), .ALUResultOut(ALUResultOut),
        .MemDataOut(MemDataOut), .WriteRegOut(WriteRegOut), .PCAddressOut(PCAddressOut),
        .BestSad(BestSad), .BestRow(BestRow), .SadCount(SadCount), .SadDone(SadDone),
        .SadState(SadState)
    );

    // clock / reset
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive_idle();
        Stall = 0; Flush = 0; RegWrite = 0; MemToReg = 0; movIn = 0; jumpIn = 0;
        ReadSp = 0; SadClear = 0; whb = 2'b00; ALUResult = '0; MemReadData = '0;
        WriteReg = '0; PCAddress = '0; SadTotal = '0; row = '0;
    endtask

    task automatic drive_sad(input logic [31:0] sad, input logic [31:0] r);
        ReadSp = 1; RegWrite = 1; SadTotal = sad; row = r;
        step();
        ReadSp = 0; RegWrite = 0;
    endtask

    function automatic logic [31:0] ref_align(input logic [1:0] w, input logic [1:0] o,
                                              input logic [31:0] m);
        logic [31:0] v;
        if (w == 2'b01) begin
            v = (m >> (8 * o)) & 32'hFF;
            return (v >= 128) ? v + 32'hFFFF_FF00 : v;
        end
        if (w == 2'b10) begin
            v = (m >> ((o >= 2) ? 16 : 0)) & 32'hFFFF;
            return (v >= 32768) ? v + 32'hFFFF_0000 : v;
        end
        return m;
    endfunction

    typedef struct {
        logic [1:0]  whb;
        logic [1:0]  off;
        logic [31:0] mem;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        logic [31:0] sad;
        logic [31:0] r;
    } samp_t;

    vec_t  vecs[10];
    samp_t sad_q[$];

    // pipeline model state
    logic        m_rw, m_m2r, m_mov, m_jmp, m_rsp;
    logic [31:0] m_alu, m_mem, m_pc;
    logic [4:0]  m_wr;

    initial begin
        vecs[0] = '{2'b00, 2'd0, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
        vecs[1] = '{2'b01, 2'd0, 32'h80FF_017F, 32'h0000_007F};
        vecs[2] = '{2'b01, 2'd1, 32'h80FF_017F, 32'h0000_0001};
        vecs[3] = '{2'b01, 2'd2, 32'h80FF_017F, 32'hFFFF_FFFF};
        vecs[4] = '{2'b01, 2'd3, 32'h80FF_017F, 32'hFFFF_FF80};
        vecs[5] = '{2'b10, 2'd0, 32'h8001_7FFF, 32'h0000_7FFF};
        vecs[6] = '{2'b10, 2'd2, 32'h8001_7FFF, 32'hFFFF_8001};
        vecs[7] = '{2'b10, 2'd1, 32'h8001_7FFF, 32'h0000_7FFF};
        vecs[8] = '{2'b10, 2'd3, 32'h8001_7FFF, 32'hFFFF_8001};
        vecs[9] = '{2'b11, 2'd2, 32'h1234_5678, 32'h1234_5678};

        drive_idle();
        Rst_n = 0;
        #12;
        chk("rst_bestsad", BestSad, 32'hFFFF_FFFF);
        chk("rst_memdata", MemDataOut, 32'h0);
        chk("rst_count", 32'(SadCount), 32'h0);
        chk("rst_state", 32'(SadState), 32'h0);
        Rst_n = 1;
        step();

        // alignment table
        for (int i = 0; i < 10; i++) begin
            whb = vecs[i].whb;
            ALUResult = 32'h1000_0000 | 32'(vecs[i].off);
            MemReadData = vecs[i].mem;
            MemToReg = i[0];
            step();
            chk($sformatf("align_%0d", i), MemDataOut, vecs[i].exp);
            chk($sformatf("alu_%0d", i), ALUResultOut, 32'h1000_0000 | 32'(vecs[i].off));
        end

        // flush beats stall
        drive_idle();
        RegWrite = 1; WriteReg = 5'd7; Stall = 1; Flush = 1; MemReadData = 32'hAAAA_5555;
        step();
        chk("flush_regwrite", 32'(RegWriteOut), 32'h0);
        chk("flush_writereg", 32'(WriteRegOut), 32'h0);
        chk("flush_memdata", MemDataOut, 32'h0);

        // stall holds
        drive_idle();
        RegWrite = 1; WriteReg = 5'd9; ALUResult = 32'h1234; PCAddress = 32'h400;
        MemReadData = 32'hCAFE_F00D; jumpIn = 1;
        step();
        Stall = 1; RegWrite = 0; WriteReg = 5'd3; ALUResult = 32'h9; PCAddress = 32'h800;
        MemReadData = 32'h0; jumpIn = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_regwrite", 32'(RegWriteOut), 32'h1);
            chk("stall_writereg", 32'(WriteRegOut), 32'd9);
            chk("stall_alu", ALUResultOut, 32'h1234);
            chk("stall_pc", PCAddressOut, 32'h400);
            chk("stall_mem", MemDataOut, 32'hCAFE_F00D);
            chk("stall_jump", 32'(jumpOut), 32'h1);
        end

        // SAD window, ties keep earlier row
        drive_idle();
        drive_sad(50, 0);
        drive_sad(20, 1);
        drive_sad(20, 2);
        chk("win_done_early", 32'(SadDone), 32'h0);
        drive_sad(90, 3);
        chk("win_best", BestSad, 32'd20);
        chk("win_row", BestRow, 32'd1);
        chk("win_count", 32'(SadCount), 32'd4);
        chk("win_done", 32'(SadDone), 32'h1);
        drive_sad(5, 4);
        chk("win5_best", BestSad, 32'd20);
        chk("win5_row", BestRow, 32'd1);
        chk("win5_count", 32'(SadCount), 32'd4);
        Stall = 1; SadClear = 1;
        step();
        Stall = 0; SadClear = 0;
        chk("clr_best", BestSad, 32'hFFFF_FFFF);
        chk("clr_count", 32'(SadCount), 32'h0);
        chk("clr_done", 32'(SadDone), 32'h0);

        // mid-cycle reset after two samples
        drive_sad(30, 7);
        drive_sad(10, 8);
        chk("pre_rst_count", 32'(SadCount), 32'd2);
        #2 Rst_n = 0;
        #1;
        chk("mid_rst_best", BestSad, 32'hFFFF_FFFF);
        chk("mid_rst_row", BestRow, 32'h0);
        chk("mid_rst_count", 32'(SadCount), 32'h0);
        chk("mid_rst_state", 32'(SadState), 32'h0);
        chk("mid_rst_alu", ALUResultOut, 32'h0);
        @(negedge Clk);
        Rst_n = 1;
        step();

        // randomized traffic vs model
        m_rw = 0; m_m2r = 0; m_mov = 0; m_jmp = 0; m_rsp = 0;
        m_alu = 0; m_mem = 0; m_pc = 0; m_wr = 0;
        sad_q.delete();
        for (int c = 0; c < 400; c++) begin
            logic [31:0] e_best, e_row;
            Stall = ($urandom_range(0, 5) == 0);
            Flush = ($urandom_range(0, 7) == 0);
            SadClear = ($urandom_range(0, 19) == 0);
            RegWrite = $urandom_range(0, 3) != 0;
            MemToReg = 1'($urandom_range(0, 1));
            movIn = 1'($urandom_range(0, 1));
            jumpIn = 1'($urandom_range(0, 1));
            ReadSp = $urandom_range(0, 2) != 0;
            whb = 2'($urandom_range(0, 3));
            ALUResult = $urandom;
            MemReadData = $urandom;
            WriteReg = 5'($urandom_range(0, 31));
            PCAddress = $urandom;
            SadTotal = $urandom_range(0, 15);
            row = $urandom_range(0, 100);

            if (Flush) begin
                m_rw = 0; m_m2r = 0; m_mov = 0; m_jmp = 0; m_rsp = 0;
                m_alu = 0; m_mem = 0; m_pc = 0; m_wr = 0;
            end else if (!Stall) begin
                m_rw = RegWrite; m_m2r = MemToReg; m_mov = movIn; m_jmp = jumpIn;
                m_rsp = ReadSp; m_alu = ALUResult; m_pc = PCAddress; m_wr = WriteReg;
                m_mem = ref_align(whb, ALUResult[1:0], MemReadData);
            end
            if (SadClear) sad_q.delete();
            else if (ReadSp && RegWrite && !Stall && !Flush && sad_q.size() < NUM_ROWS)
                sad_q.push_back('{SadTotal, row});
            e_best = 32'hFFFF_FFFF;
            e_row = 0;
            foreach (sad_q[k]) begin
                if (k == 0 || sad_q[k].sad < e_best) begin
                    e_best = sad_q[k].sad;
                    e_row = sad_q[k].r;
                end
            end

            step();
            chk("rnd_regwrite", 32'(RegWriteOut), 32'(m_rw));
            chk("rnd_memtoreg", 32'(MemToRegOut), 32'(m_m2r));
            chk("rnd_mov", 32'(movOut), 32'(m_mov));
            chk("rnd_jump", 32'(jumpOut), 32'(m_jmp));
            chk("rnd_readsp", 32'(ReadSpOut), 32'(m_rsp));
            chk("rnd_alu", ALUResultOut, m_alu);
            chk("rnd_mem", MemDataOut, m_mem);
            chk("rnd_wr", 32'(WriteRegOut), 32'(m_wr));
            chk("rnd_pc", PCAddressOut, m_pc);
            chk("rnd_best", BestSad, e_best);
            chk("rnd_row", BestRow, e_row);
            chk("rnd_count", 32'(SadCount), 32'(sad_q.size()));
            chk("rnd_done", 32'(SadDone), 32'(sad_q.size() == NUM_ROWS));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
